// File: rtl/lc4_xm_stage.sv
// LC4 execute-to-memory boundary: X/M register, branch/jump redirect, NZP register with late load update.
// Optional perf counters are enabled by defining LC4_XM_PERF_CNT_EN.
module lc4_xm_stage #(
    parameter logic [2:0] NZP_RESET = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gwe,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic [15:0] i_insn,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_alu_result,
    input  logic [15:0] i_r2data,
    input  logic [2:0]  i_rd_sel,
    input  logic        i_regfile_we,
    input  logic        i_nzp_we,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_is_branch,
    input  logic        i_is_control,
    input  logic        i_is_link,
    input  logic        i_wb_nzp_we,
    input  logic [2:0]  i_wb_nzp,
    output logic        o_valid,
    output logic [15:0] o_insn,
    output logic [15:0] o_pc,
    output logic [15:0] o_result,
    output logic [15:0] o_store_data,
    output logic [2:0]  o_rd_sel,
    output logic        o_regfile_we,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic [2:0]  o_nzp,
    output logic        o_redirect,
    output logic [15:0] o_redirect_pc
`ifdef LC4_XM_PERF_CNT_EN
    ,
    output logic [15:0] o_redirect_cnt,
    output logic [15:0] o_bubble_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic [15:0] insn;
        logic [15:0] pc;
        logic [15:0] result;
        logic [15:0] store_data;
        logic [2:0]  rd_sel;
        logic        regfile_we;
        logic        is_load;
        logic        is_store;
    } xm_t;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        else if (v[15])    return 3'b100;
        else               return 3'b001;
    endfunction

    xm_t        xm_q, xm_d;
    logic [2:0] nzp_q, nzp_d;
    logic [1:0] ld_cnt_q, ld_cnt_d;

    logic        capture, bubble, wb_apply, taken;
    logic [2:0]  eff_nzp;
    logic [15:0] wb_val;

    assign capture = gwe & ~i_flush & ~i_stall;
    assign bubble  = gwe & i_flush;
    assign wb_val  = i_is_link ? (i_pc + 16'd1) : i_alu_result;

    // A W-stage load NZP only counts while a load writer is still outstanding.
    assign wb_apply = i_wb_nzp_we & (ld_cnt_q != 2'd0);
    assign eff_nzp  = wb_apply ? i_wb_nzp : nzp_q;
    assign taken    = i_valid & i_is_branch & ((i_insn[11:9] & eff_nzp) != 3'b000);

    assign o_redirect    = gwe & ~i_stall & ~i_flush & rst_n & i_valid & (taken | i_is_control);
    assign o_redirect_pc = i_alu_result;

    always_comb begin
        xm_d = xm_q;
        if (bubble) begin
            xm_d = '0;
        end else if (capture) begin
            xm_d.valid      = i_valid;
            xm_d.insn       = i_insn;
            xm_d.pc         = i_pc;
            xm_d.result     = wb_val;
            xm_d.store_data = i_r2data;
            xm_d.rd_sel     = i_rd_sel;
            xm_d.regfile_we = i_regfile_we & i_valid;
            xm_d.is_load    = i_is_load & i_valid;
            xm_d.is_store   = i_is_store & i_valid;
        end
    end

    always_comb begin
        nzp_d    = nzp_q;
        ld_cnt_d = ld_cnt_q;
        if (gwe) begin
            if (wb_apply) begin
                nzp_d    = i_wb_nzp;
                ld_cnt_d = ld_cnt_q - 2'd1;
            end
            if (capture && i_valid && i_nzp_we) begin
                if (!i_is_load) begin
                    // Younger non-load writer supersedes any pending load result.
                    nzp_d    = nzp_of(wb_val);
                    ld_cnt_d = 2'd0;
                end else if (!wb_apply) begin
                    ld_cnt_d = (ld_cnt_q == 2'd2) ? 2'd2 : ld_cnt_q + 2'd1;
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xm_q     <= '0;
            nzp_q    <= NZP_RESET;
            ld_cnt_q <= 2'd0;
        end else begin
            xm_q     <= xm_d;
            nzp_q    <= nzp_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    assign o_valid      = xm_q.valid;
    assign o_insn       = xm_q.insn;
    assign o_pc         = xm_q.pc;
    assign o_result     = xm_q.result;
    assign o_store_data = xm_q.store_data;
    assign o_rd_sel     = xm_q.rd_sel;
    assign o_regfile_we = xm_q.regfile_we;
    assign o_is_load    = xm_q.is_load;
    assign o_is_store   = xm_q.is_store;
    assign o_nzp        = nzp_q;

`ifdef LC4_XM_PERF_CNT_EN
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (o_redirect && redirect_cnt_q != 16'hFFFF) redirect_cnt_d = redirect_cnt_q + 16'd1;
        if (bubble && bubble_cnt_q != 16'hFFFF)       bubble_cnt_d   = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_cnt_q <= 16'd0;
            bubble_cnt_q   <= 16'd0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign o_redirect_cnt = redirect_cnt_q;
    assign o_bubble_cnt   = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_lc4_xm_stage.sv
// Directed bench for lc4_xm_stage: reference model of the X/M stage checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_lc4_xm_stage;

    logic        clk = 1'b0;
    logic        rst_n, gwe, i_stall, i_flush, i_valid;
    logic [15:0] i_insn, i_pc, i_alu_result, i_r2data;
    logic [2:0]  i_rd_sel, i_wb_nzp;
    logic        i_regfile_we, i_nzp_we, i_is_load, i_is_store, i_is_branch;
    logic        i_is_control, i_is_link, i_wb_nzp_we;
    logic        o_valid, o_regfile_we, o_is_load, o_is_store, o_redirect;
    logic [15:0] o_insn, o_pc, o_result, o_store_data, o_redirect_pc;
    logic [2:0]  o_rd_sel, o_nzp;
`ifdef LC4_XM_PERF_CNT_EN
    logic [15:0] o_redirect_cnt, o_bubble_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    lc4_xm_stage dut (
        .clk(clk), .rst_n(rst_n), .gwe(gwe), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_insn(i_insn), .i_pc(i_pc), .i_alu_result(i_alu_result),
        .i_r2data(i_r2data), .i_rd_sel(i_rd_sel), .i_regfile_we(i_regfile_we),
        .i_nzp_we(i_nzp_we), .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_is_branch(i_is_branch), .i_is_control(i_is_control), .i_is_link(i_is_link),
        .i_wb_nzp_we(i_wb_nzp_we), .i_wb_nzp(i_wb_nzp),
        .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc), .o_result(o_result),
        .o_store_data(o_store_data), .o_rd_sel(o_rd_sel), .o_regfile_we(o_regfile_we),
        .o_is_load(o_is_load), .o_is_store(o_is_store), .o_nzp(o_nzp),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
`ifdef LC4_XM_PERF_CNT_EN
        , .o_redirect_cnt(o_redirect_cnt), .o_bubble_cnt(o_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_live = 1'b0;
    logic        m_valid, m_rwe, m_ld, m_st;
    logic [15:0] m_insn, m_pc, m_result, m_sd;
    logic [2:0]  m_rd, m_nzp;
    int          m_pend;   // load NZP writers still awaiting their W-stage value

    function automatic logic [2:0] sign_class(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        if (v >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic model_redirect();
        logic [2:0] cc;
        logic       br;
        if (!rst_n || !gwe || i_stall || i_flush || !i_valid) return 1'b0;
        cc = (i_wb_nzp_we && m_pend > 0) ? i_wb_nzp : m_nzp;
        br = i_is_branch && ((i_insn[11:9] & cc) != 3'b000);
        return br || i_is_control;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1'b1;
            {m_valid, m_rwe, m_ld, m_st} = 4'b0;
            m_insn = 0; m_pc = 0; m_result = 0; m_sd = 0; m_rd = 0;
            m_nzp = 3'b010; m_pend = 0;
        end else if (gwe) begin
            logic        wb_hit, cap, writer;
            logic [15:0] val;
            wb_hit = i_wb_nzp_we && (m_pend > 0);
            cap    = !i_flush && !i_stall;
            val    = i_is_link ? 16'((32'(i_pc) + 1) % 65536) : i_alu_result;
            writer = cap && i_valid && i_nzp_we;
            if (writer && !i_is_load) begin
                m_nzp = sign_class(val); m_pend = 0;
            end else if (writer) begin
                if (wb_hit) m_nzp = i_wb_nzp;
                else if (m_pend < 2) m_pend++;
            end else if (wb_hit) begin
                m_nzp = i_wb_nzp; m_pend--;
            end
            if (i_flush) begin
                {m_valid, m_rwe, m_ld, m_st} = 4'b0;
                m_insn = 0; m_pc = 0; m_result = 0; m_sd = 0; m_rd = 0;
            end else if (cap) begin
                m_valid = i_valid; m_insn = i_insn; m_pc = i_pc; m_result = val;
                m_sd = i_r2data; m_rd = i_rd_sel;
                m_rwe = i_regfile_we && i_valid; m_ld = i_is_load && i_valid;
                m_st = i_is_store && i_valid;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One compare process against the model, on the inactive edge.
    always @(negedge clk) begin
        if (m_live) begin
            logic r;
            r = model_redirect();
            chk("m.valid", 16'(o_valid), 16'(m_valid));
            chk("m.insn", o_insn, m_insn);
            chk("m.pc", o_pc, m_pc);
            chk("m.result", o_result, m_result);
            chk("m.store_data", o_store_data, m_sd);
            chk("m.rd_sel", 16'(o_rd_sel), 16'(m_rd));
            chk("m.regfile_we", 16'(o_regfile_we), 16'(m_rwe));
            chk("m.is_load", 16'(o_is_load), 16'(m_ld));
            chk("m.is_store", 16'(o_is_store), 16'(m_st));
            chk("m.nzp", 16'(o_nzp), 16'(m_nzp));
            chk("m.redirect", 16'(o_redirect), 16'(r));
            if (r) chk("m.redirect_pc", o_redirect_pc, i_alu_result);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gwe = 1; i_stall = 0; i_flush = 0; i_valid = 0;
        i_insn = 0; i_pc = 0; i_alu_result = 0; i_r2data = 0; i_rd_sel = 0;
        i_regfile_we = 0; i_nzp_we = 0; i_is_load = 0; i_is_store = 0;
        i_is_branch = 0; i_is_control = 0; i_is_link = 0; i_wb_nzp_we = 0; i_wb_nzp = 0;
    endtask

    task automatic load(input logic [15:0] addr);
        idle(); i_valid = 1; i_insn = 16'h6000; i_alu_result = addr;
        i_is_load = 1; i_nzp_we = 1; i_regfile_we = 1; i_rd_sel = 3'd2;
    endtask

    task automatic alu_op(input logic [15:0] res);
        idle(); i_valid = 1; i_insn = 16'h1000; i_alu_result = res;
        i_nzp_we = 1; i_regfile_we = 1; i_rd_sel = 3'd1;
    endtask

    task automatic branch(input logic [2:0] mask, input logic [15:0] tgt);
        idle(); i_valid = 1; i_insn = {4'b0000, mask, 9'h0}; i_alu_result = tgt; i_is_branch = 1;
    endtask

    initial begin
        idle();
        rst_n = 0; i_valid = 1; i_is_control = 1; i_alu_result = 16'h1234;
        #1;
        chk("reset.redirect", 16'(o_redirect), 16'h0);
        tick(); tick();
        chk("reset.valid", 16'(o_valid), 16'h0);
        chk("reset.nzp", 16'(o_nzp), 16'h2);
        chk("reset.result", o_result, 16'h0);
        rst_n = 1;

        // ADD with negative result, then BRn resolves against it
        alu_op(16'h8000); tick();
        chk("add.result", o_result, 16'h8000);
        chk("add.nzp", 16'(o_nzp), 16'h4);
        branch(3'b100, 16'h0042); #1;
        chk("brn.redirect", 16'(o_redirect), 16'h1);
        chk("brn.pc", o_redirect_pc, 16'h0042);
        tick();
        branch(3'b000, 16'h0099); #1;
        chk("nop.redirect", 16'(o_redirect), 16'h0);
        tick();

        // JSR: link value PC+1 into R7, sets NZP from link value
        idle(); i_valid = 1; i_insn = 16'h4800; i_pc = 16'h0010; i_alu_result = 16'h0200;
        i_is_control = 1; i_is_link = 1; i_regfile_we = 1; i_rd_sel = 3'd7; i_nzp_we = 1; #1;
        chk("jsr.redirect", 16'(o_redirect), 16'h1);
        chk("jsr.pc", o_redirect_pc, 16'h0200);
        tick();
        chk("jsr.result", o_result, 16'h0011);
        chk("jsr.rd", 16'(o_rd_sel), 16'h7);
        chk("jsr.nzp", 16'(o_nzp), 16'h1);
        i_pc = 16'hFFFF; tick();
        chk("jsr.wrap", o_result, 16'h0000);

        // load then zero-writing ADD: later wb is stale and ignored
        load(16'h4000); tick();
        chk("ldr.nzp_hold", 16'(o_nzp), 16'h2);
        chk("ldr.is_load", 16'(o_is_load), 16'h1);
        alu_op(16'h0000); tick();
        chk("add0.nzp", 16'(o_nzp), 16'h2);
        idle(); i_wb_nzp_we = 1; i_wb_nzp = 3'b001; tick();
        chk("stale_wb.nzp", 16'(o_nzp), 16'h2);

        // two loads then two wb updates; BRp sees the forwarded second one
        load(16'h4001); tick();
        load(16'h4002); tick();
        idle(); i_wb_nzp_we = 1; i_wb_nzp = 3'b100; tick();
        chk("wb1.nzp", 16'(o_nzp), 16'h4);
        branch(3'b001, 16'h0077); i_wb_nzp_we = 1; i_wb_nzp = 3'b001; #1;
        chk("brp.redirect", 16'(o_redirect), 16'h1);
        chk("brp.pc", o_redirect_pc, 16'h0077);
        tick();
        chk("wb2.nzp", 16'(o_nzp), 16'h1);

        // saturation: three loads leave two pending; third wb ignored
        load(16'h5000); tick(); load(16'h5001); tick(); load(16'h5002); tick();
        idle(); i_wb_nzp_we = 1; i_wb_nzp = 3'b010; tick();
        i_wb_nzp = 3'b100; tick();
        chk("sat.wb2", 16'(o_nzp), 16'h4);
        i_wb_nzp = 3'b001; tick();
        chk("sat.wb3", 16'(o_nzp), 16'h4);

        // load captured alongside a wb update
        load(16'h6000); tick();
        load(16'h6001); i_wb_nzp_we = 1; i_wb_nzp = 3'b010; tick();
        chk("ld_wb.nzp", 16'(o_nzp), 16'h2);
        idle(); i_wb_nzp_we = 1; i_wb_nzp = 3'b001; tick();
        chk("ld_wb.pending", 16'(o_nzp), 16'h1);

        // store capture, then stall holds and a wb update still lands
        idle(); i_valid = 1; i_insn = 16'h7000; i_is_store = 1; i_r2data = 16'hBEEF;
        i_alu_result = 16'h3000; tick();
        chk("str.sd", o_store_data, 16'hBEEF);
        chk("str.flag", 16'(o_is_store), 16'h1);
        load(16'h3100); tick();
        alu_op(16'h0005); i_stall = 1; i_is_control = 1; i_wb_nzp_we = 1; i_wb_nzp = 3'b100; #1;
        chk("stall.redirect", 16'(o_redirect), 16'h0);
        tick();
        chk("stall.hold", o_result, 16'h3100);
        chk("stall.wb", 16'(o_nzp), 16'h4);

        // stall and flush together: bubble wins
        i_flush = 1; i_wb_nzp_we = 0; tick();
        chk("flush.valid", 16'(o_valid), 16'h0);
        chk("flush.result", o_result, 16'h0000);
        chk("flush.nzp", 16'(o_nzp), 16'h4);

        // invalid insn writes nothing
        alu_op(16'h0001); i_valid = 0; tick();
        chk("inv.rwe", 16'(o_regfile_we), 16'h0);
        chk("inv.nzp", 16'(o_nzp), 16'h4);

        // gwe=0 freezes everything
        alu_op(16'h0123); i_is_control = 1; gwe = 0; #1;
        chk("gwe.redirect", 16'(o_redirect), 16'h0);
        tick(); tick();
        chk("gwe.result", o_result, 16'h0001);
        chk("gwe.nzp", 16'(o_nzp), 16'h4);
        gwe = 1; tick();
        chk("gwe.release", o_result, 16'h0123);
        idle(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
